// File: rtl/ascii_stream_player_if.sv
// Bus bundle for the ASCII stream player: ioctl download, external memory,
// live keyboard and CPU keyboard-register signals.
interface ascii_stream_player_if #(
    parameter int ADDR_W = 16
);
    logic              ioctl_download;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_wr;
    logic              mem_rd;
    logic [7:0]        mem_dout;
    logic              mem_ready;
    logic [6:0]        kbd_ascii;
    logic              kbd_strobe;
    logic              cs;
    logic              address;
    logic [7:0]        dout;
    logic              data_ready;

    modport master (
        output ioctl_download, ioctl_addr, ioctl_dout, ioctl_wr,
        output mem_dout, mem_ready, kbd_ascii, kbd_strobe, cs, address,
        input  mem_addr, mem_din, mem_wr, mem_rd, dout, data_ready
    );

    modport slave (
        input  ioctl_download, ioctl_addr, ioctl_dout, ioctl_wr,
        input  mem_dout, mem_ready, kbd_ascii, kbd_strobe, cs, address,
        output mem_addr, mem_din, mem_wr, mem_rd, dout, data_ready
    );
endinterface

// File: rtl/ascii_stream_player.sv
// Paced text-injection engine: replays a downloaded byte stream into the
// Apple-1 keyboard register as if typed, with flow control and live-key abort.
module ascii_stream_player #(
    parameter int ADDR_W   = 16,
    parameter int PACE_DIV = 40000,
    parameter int EOL_DIV  = 400000,
    parameter int NL_MODE  = 1,
    parameter int UPCASE   = 1
) (
    input logic                  clk25,
    input logic                  rst,
    ascii_stream_player_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, PACE, FETCH, WAITCPU} state_t;

    localparam int CNT_W = $clog2(EOL_DIV + 1);
    localparam logic [CNT_W-1:0] PACE_RELOAD = CNT_W'(PACE_DIV - 1);
    localparam logic [CNT_W-1:0] EOL_RELOAD  = CNT_W'(EOL_DIV - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_have_data;
    logic              r_rdy;
    logic [6:0]        r_ascii;
    logic [7:0]        r_dout;
    logic              r_mem_rd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_prev_cr;

    logic [6:0]        w_byte;
    logic              w_drop;
    logic              w_at_end;
    logic              w_playing;
    logic [CNT_W-1:0]  w_reload;
    logic              w_unused;

    function automatic logic [6:0] foldCase(input logic [6:0] c);
        if (UPCASE != 0 && c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
        return c;
    endfunction

    // Newline policy first (it needs the raw LF), then case folding.
    always_comb begin
        w_byte = bus.mem_dout[6:0];
        w_drop = 1'b0;
        if (w_byte == 7'h0A) begin
            if (NL_MODE == 1) begin
                w_byte = 7'h0D;
            end else if (NL_MODE == 2) begin
                if (r_prev_cr) w_drop = 1'b1;
                else           w_byte = 7'h0D;
            end
        end
        w_byte = foldCase(w_byte);
    end

    assign w_at_end  = (r_rd_ptr == r_last_addr);
    assign w_playing = (r_state == PACE) || (r_state == FETCH) || (r_state == WAITCPU);
    assign w_reload  = r_prev_cr ? EOL_RELOAD : PACE_RELOAD;
    assign w_unused  = bus.mem_dout[7];

    assign bus.mem_addr   = bus.ioctl_download ? bus.ioctl_addr : r_rd_ptr;
    assign bus.mem_din    = bus.ioctl_wr ? bus.ioctl_dout : 8'h00;
    assign bus.mem_wr     = bus.ioctl_download & bus.ioctl_wr;
    assign bus.mem_rd     = r_mem_rd & ~bus.ioctl_download;
    assign bus.dout       = r_dout;
    assign bus.data_ready = w_playing;

    // CPU read clears rdy early in the block so that a new character later
    // in the same cycle wins; download beats live keys, which beat playback.
    always_ff @(posedge clk25) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rd_ptr    <= '0;
            r_last_addr <= '0;
            r_have_data <= 1'b0;
            r_rdy       <= 1'b0;
            r_ascii     <= '0;
            r_dout      <= '0;
            r_mem_rd    <= 1'b0;
            r_cnt       <= '0;
            r_prev_cr   <= 1'b0;
        end else begin
            if (bus.cs) begin
                if (!bus.address) begin
                    r_dout <= {1'b1, r_ascii};
                    r_rdy  <= 1'b0;
                end else begin
                    r_dout <= {r_rdy, 7'b0};
                end
            end
            if (bus.kbd_strobe) begin
                r_ascii <= foldCase(bus.kbd_ascii);
                r_rdy   <= 1'b1;
            end
            if (bus.ioctl_download) begin
                r_mem_rd <= 1'b0;
                if (r_state != LOAD) begin
                    r_state     <= LOAD;
                    r_have_data <= 1'b0;
                end
                if (bus.ioctl_wr) begin
                    r_last_addr <= bus.ioctl_addr;
                    r_have_data <= 1'b1;
                end
            end else if (bus.kbd_strobe && w_playing) begin
                r_state  <= IDLE;
                r_mem_rd <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: r_state <= IDLE;
                    LOAD: begin
                        if (r_have_data) begin
                            r_state  <= PACE;
                            r_rd_ptr <= '0;
                            r_cnt    <= PACE_RELOAD;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    PACE: begin
                        if (r_cnt == '0) begin
                            r_state  <= FETCH;
                            r_mem_rd <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    FETCH: begin
                        if (bus.mem_ready) begin
                            r_mem_rd <= 1'b0;
                            if (w_drop) begin
                                r_prev_cr <= 1'b0;
                                if (w_at_end) begin
                                    r_state <= IDLE;
                                end else begin
                                    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                                    r_cnt    <= w_reload;
                                    r_state  <= PACE;
                                end
                            end else begin
                                r_ascii   <= w_byte;
                                r_rdy     <= 1'b1;
                                r_prev_cr <= (w_byte == 7'h0D);
                                r_state   <= WAITCPU;
                            end
                        end
                    end
                    WAITCPU: begin
                        if (!r_rdy) begin
                            if (w_at_end) begin
                                r_state <= IDLE;
                            end else begin
                                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                                r_cnt    <= w_reload;
                                r_state  <= PACE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ascii_stream_player.sv
// Directed bench for ascii_stream_player: a translation vector table plus
// hand-written sequences for pacing, CRLF, key abort, reset and full-span download.
module tb_ascii_stream_player;
    localparam int ADDR_W   = 4;
    localparam int PACE_DIV = 8;
    localparam int EOL_DIV  = 40;
    localparam int NL_MODE  = 2;
    localparam int UPCASE   = 1;

    typedef struct {
        string      name;
        logic [7:0] inByte;
        logic [7:0] expDout;
    } vec_t;

    logic clk25 = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] dlBuf [16];
    logic [7:0] memArray [16];
    int   memLat;
    vec_t vecs [9];

    always #5 clk25 = ~clk25;

    ascii_stream_player_if #(.ADDR_W(ADDR_W)) bus ();

    ascii_stream_player #(
        .ADDR_W(ADDR_W), .PACE_DIV(PACE_DIV), .EOL_DIV(EOL_DIV),
        .NL_MODE(NL_MODE), .UPCASE(UPCASE)
    ) dut (
        .clk25(clk25),
        .rst  (rst),
        .bus  (bus)
    );

    // Memory model: writes land immediately, reads answer after a short latency.
    always @(posedge clk25) begin
        if (rst) begin
            bus.mem_ready <= 1'b0;
            bus.mem_dout  <= 8'h00;
            memLat        <= 0;
        end else begin
            bus.mem_ready <= 1'b0;
            if (bus.mem_wr) memArray[bus.mem_addr] <= bus.mem_din;
            if (bus.mem_rd && !bus.mem_ready) begin
                if (memLat == 2) begin
                    bus.mem_ready <= 1'b1;
                    bus.mem_dout  <= memArray[bus.mem_addr];
                    memLat        <= 0;
                end else begin
                    memLat <= memLat + 1;
                end
            end else begin
                memLat <= 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int value, input int lo, input int hi);
        checks++;
        if (value < lo || value > hi) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, value, lo, hi);
        end
    endtask

    task automatic cpuRead(input logic addr, output logic [7:0] data);
        bus.cs = 1'b1;
        bus.address = addr;
        @(negedge clk25);
        bus.cs = 1'b0;
        data = bus.dout;
    endtask

    task automatic download(input int n);
        @(negedge clk25);
        bus.ioctl_download = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.ioctl_addr = ADDR_W'(i);
            bus.ioctl_dout = dlBuf[i];
            bus.ioctl_wr   = 1'b1;
            @(negedge clk25);
            bus.ioctl_wr   = 1'b0;
            @(negedge clk25);
        end
        bus.ioctl_download = 1'b0;
    endtask

    // Poll status until a character is pending, then take it with a data read.
    task automatic waitChar(input int budget, output logic [7:0] data, output int cycles);
        logic [7:0] status;
        bit got;
        got = 1'b0;
        cycles = 0;
        data = 8'h00;
        while (cycles < budget && !got) begin
            cpuRead(1'b1, status);
            cycles++;
            if (status[7]) got = 1'b1;
        end
        if (got) begin
            cpuRead(1'b0, data);
        end else begin
            checks++;
            failures++;
            $display("[TB] FAIL waitChar: got no character within %0d cycles expected one", budget);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, output logic [7:0] data);
        int cyc;
        dlBuf[0] = b;
        download(1);
        waitChar(200, data, cyc);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] s;
        logic [7:0] crlfExp [4];
        int cyc;
        int n;
        int rdSeen;

        vecs[0] = '{"lower_a",    8'h61, 8'hC1};
        vecs[1] = '{"lower_z",    8'h7A, 8'hDA};
        vecs[2] = '{"upper_A",    8'h41, 8'hC1};
        vecs[3] = '{"brace",      8'h7B, 8'hFB};
        vecs[4] = '{"backtick",   8'h60, 8'hE0};
        vecs[5] = '{"at_sign",    8'h40, 8'hC0};
        vecs[6] = '{"bit7_a",     8'hE1, 8'hC1};
        vecs[7] = '{"lone_lf",    8'h0A, 8'h8D};
        vecs[8] = '{"cr",         8'h0D, 8'h8D};

        rst = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_addr = '0;
        bus.ioctl_dout = 8'h00;
        bus.ioctl_wr = 1'b0;
        bus.kbd_ascii = 7'h00;
        bus.kbd_strobe = 1'b0;
        bus.cs = 1'b0;
        bus.address = 1'b0;
        repeat (3) @(negedge clk25);
        rst = 1'b0;
        $display("[TB] reset released");

        checkOutput("reset_dout", bus.dout, 8'h00);
        checkOutput("reset_data_ready", bus.data_ready, 1'b0);
        checkOutput("reset_mem_rd", bus.mem_rd, 1'b0);
        cpuRead(1'b1, s);
        checkOutput("reset_status", s, 8'h00);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].inByte, d);
            checkOutput(vecs[i].name, d, vecs[i].expDout);
            repeat (3) @(negedge clk25);
            checkOutput("table_idle", bus.data_ready, 1'b0);
        end

        $display("[TB] AB flow control");
        dlBuf[0] = 8'h41;
        dlBuf[1] = 8'h42;
        download(2);
        repeat (PACE_DIV * 6) @(negedge clk25);
        cpuRead(1'b1, s);
        checkOutput("ab_status_pending", s, 8'h80);
        cpuRead(1'b0, d);
        checkOutput("ab_first_char", d, 8'hC1);
        cpuRead(1'b1, s);
        checkOutput("ab_status_cleared", s, 8'h00);
        waitChar(100, d, cyc);
        checkOutput("ab_second_char", d, 8'hC2);
        checkRange("ab_pace_gap", cyc, PACE_DIV, PACE_DIV + 12);
        repeat (3) @(negedge clk25);
        checkOutput("ab_idle", bus.data_ready, 1'b0);

        $display("[TB] CRLF sequence");
        dlBuf[0] = 8'h61; dlBuf[1] = 8'h0D; dlBuf[2] = 8'h0A; dlBuf[3] = 8'h20; dlBuf[4] = 8'h62;
        crlfExp[0] = 8'hC1; crlfExp[1] = 8'h8D; crlfExp[2] = 8'hA0; crlfExp[3] = 8'hC2;
        download(5);
        for (int i = 0; i < 4; i++) begin
            waitChar(400, d, cyc);
            checkOutput("crlf_char", d, crlfExp[i]);
            if (i == 1) checkRange("crlf_gap_before_cr", cyc, 1, EOL_DIV - 1);
            if (i == 2) checkRange("crlf_gap_after_cr", cyc, EOL_DIV, 400);
        end
        repeat (3) @(negedge clk25);
        checkOutput("crlf_idle", bus.data_ready, 1'b0);

        $display("[TB] live key abort");
        dlBuf[0] = 8'h30; dlBuf[1] = 8'h31; dlBuf[2] = 8'h32; dlBuf[3] = 8'h33;
        download(4);
        waitChar(100, d, cyc);
        checkOutput("abort_first_char", d, 8'hB0);
        repeat (2) @(negedge clk25);
        checkOutput("abort_playing", bus.data_ready, 1'b1);
        bus.kbd_ascii = 7'h78;
        bus.kbd_strobe = 1'b1;
        @(negedge clk25);
        bus.kbd_strobe = 1'b0;
        checkOutput("abort_data_ready", bus.data_ready, 1'b0);
        rdSeen = 0;
        repeat (60) begin
            @(negedge clk25);
            if (bus.mem_rd) rdSeen++;
        end
        checkOutput("abort_no_mem_rd", rdSeen, 0);
        cpuRead(1'b1, s);
        checkOutput("abort_key_status", s, 8'h80);
        cpuRead(1'b0, d);
        checkOutput("abort_key_char", d, 8'hD8);

        $display("[TB] empty download");
        @(negedge clk25);
        bus.ioctl_download = 1'b1;
        repeat (4) @(negedge clk25);
        bus.ioctl_download = 1'b0;
        repeat (20) @(negedge clk25);
        checkOutput("empty_idle", bus.data_ready, 1'b0);
        cpuRead(1'b1, s);
        checkOutput("empty_status", s, 8'h00);

        $display("[TB] reset during fetch");
        dlBuf[0] = 8'h51;
        download(1);
        cpuRead(1'b0, d);
        n = 0;
        while (!bus.mem_rd && n < 50) begin
            @(negedge clk25);
            n++;
        end
        checkOutput("rst_reached_fetch", bus.mem_rd, 1'b1);
        rst = 1'b1;
        @(negedge clk25);
        rst = 1'b0;
        checkOutput("rst_mem_rd", bus.mem_rd, 1'b0);
        checkOutput("rst_dout", bus.dout, 8'h00);
        checkOutput("rst_data_ready", bus.data_ready, 1'b0);
        repeat (60) @(negedge clk25);
        checkOutput("rst_no_replay", bus.data_ready, 1'b0);
        cpuRead(1'b1, s);
        checkOutput("rst_status", s, 8'h00);

        $display("[TB] full-span download");
        for (int i = 0; i < 16; i++) dlBuf[i] = 8'(8'h61 + i);
        download(16);
        for (int i = 0; i < 16; i++) begin
            waitChar(100, d, cyc);
            checkOutput("span_char", d, 8'(8'hC1 + i));
        end
        repeat (3) @(negedge clk25);
        checkOutput("span_idle", bus.data_ready, 1'b0);
        checkOutput("span_rd_ptr", bus.mem_addr, 4'hF);
        repeat (40) @(negedge clk25);
        cpuRead(1'b1, s);
        checkOutput("span_no_extra", s, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
